digit_line_bcd_sprite: RTL

//  - Next-generation HUD number renderer: shows an unsigned Value as NUM_DIGIT decimal glyphs at (COOR_X, COOR_Y).
//  - Converts binary to BCD sequentially (shift-add-3, one bit per clock) instead of with combinational divide/mod.
//  - Double-buffers the digits so a change in Value never tears a frame.
//  - Sits between the game-state registers and the font ROM / colour mapper in draw_engine.

---
 rtl/digit_line_bcd_sprite.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/digit_line_bcd_sprite.sv
// digit_line_bcd_sprite: HUD number renderer.
// Samples an unsigned value on an Update strobe, converts it to BCD with a
// sequential shift-add-3 (one bit per clock), commits the digits to a
// display bank and renders the glyph box under the current pixel.
// Optional feature macro: LEADING_ZERO_BLANK_EN (store leading zeros as blank).
//
// Handshake: Update is a single-cycle strobe and is always accepted. Busy is
// high while a conversion runs (SHIFT and COMMIT); an Update seen while busy
// is parked in a one-deep pending slot (last write wins). Done pulses for one
// cycle exactly when the new digits land in the display bank.
module digit_line_bcd_sprite #(
    parameter int COOR_X    = 16,
    parameter int COOR_Y    = 60,
    parameter int NUM_DIGIT = 3,
    parameter int VALUE_W   = 10,
    parameter int DIGIT_W   = 8,
    parameter int DIGIT_H   = 16
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic [9:0]                 DrawX,
    input  logic [9:0]                 DrawY,
    input  logic [VALUE_W-1:0]         Value,
    input  logic                       Update,
    output logic                       Busy,
    output logic                       Done,
    output logic                       IsDigit,
    output logic [3:0]                 DigitCode,
    output logic [$clog2(DIGIT_W)-1:0] GlyphX,
    output logic [$clog2(DIGIT_H)-1:0] GlyphY,
    output logic [1:0]                 dbg_state
);

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam int GX_W  = $clog2(DIGIT_W);
    localparam int GY_W  = $clog2(DIGIT_H);
    localparam int BCD_W = 4 * NUM_DIGIT;
    localparam int CNT_W = $clog2(VALUE_W + 1);

    localparam logic [VALUE_W-1:0] MAX_VAL = VALUE_W'(pow10(NUM_DIGIT) - 1);
    localparam logic [CNT_W-1:0]   CNT_TOP = CNT_W'(VALUE_W - 1);

    localparam logic [10:0] X_LO = 11'(COOR_X);
    localparam logic [10:0] X_HI = 11'(COOR_X + NUM_DIGIT * DIGIT_W);
    localparam logic [10:0] Y_LO = 11'(COOR_Y);
    localparam logic [10:0] Y_HI = 11'(COOR_Y + DIGIT_H);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    logic [1:0]         state;
    logic [VALUE_W-1:0] bin_sr;
    logic [BCD_W-1:0]   bcd_sr;
    logic [CNT_W-1:0]   bit_cnt;
    logic               pend;
    logic [VALUE_W-1:0] pend_val;
    logic [BCD_W-1:0]   bank;

    logic [VALUE_W-1:0] sat_val;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   commit_digits;

    logic [9:0]         rel_x;
    logic [9:0]         digit_idx;
    logic               in_box;
    logic [3:0]         code_sel;

    assign sat_val   = (Value > MAX_VAL) ? MAX_VAL : Value;
    assign Busy      = (state != IDLE);
    assign dbg_state = state;

    // Add-3 correction on every BCD nibble that is 5 or more before the shift
    always_comb begin
        bcd_adj = bcd_sr;
        for (int n = 0; n < NUM_DIGIT; n++) begin
            if (bcd_sr[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd_sr[4*n +: 4] + 4'd3;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic seen_nz;

    // Blank zeros left of the first non-zero digit; the last digit always shows
    always_comb begin
        commit_digits = bcd_sr;
        seen_nz       = 1'b0;
        for (int i = NUM_DIGIT - 1; i >= 1; i--) begin
            if (bcd_sr[4*i +: 4] != 4'd0) seen_nz = 1'b1;
            if (!seen_nz) commit_digits[4*i +: 4] = 4'hF;
        end
    end
`else
    // Zero-padded display: commit the BCD register as is
    always_comb begin
        commit_digits = bcd_sr;
    end
`endif

    // Conversion FSM: capture, shift-add-3 for VALUE_W cycles, commit
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state    <= IDLE;
            Done     <= 1'b0;
            pend     <= 1'b0;
            pend_val <= '0;
            bin_sr   <= '0;
            bcd_sr   <= '0;
            bit_cnt  <= '0;
            bank     <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Update) begin
                        bin_sr  <= sat_val;
                        bcd_sr  <= '0;
                        bit_cnt <= CNT_TOP;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd_sr, bin_sr} <= {bcd_adj[BCD_W-2:0], bin_sr, 1'b0};
                    if (bit_cnt == '0) state <= COMMIT;
                    else bit_cnt <= bit_cnt - 1'b1;
                    if (Update) begin
                        pend     <= 1'b1;
                        pend_val <= sat_val;
                    end
                end
                COMMIT: begin
                    bank <= commit_digits;
                    Done <= 1'b1;
                    // An Update on this very cycle is the newest pending value
                    if (Update || pend) begin
                        bin_sr  <= Update ? sat_val : pend_val;
                        bcd_sr  <= '0;
                        bit_cnt <= CNT_TOP;
                        pend    <= 1'b0;
                        state   <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rel_x     = DrawX - 10'(COOR_X);
    assign digit_idx = rel_x >> GX_W;
    assign in_box    = ({1'b0, DrawX} >= X_LO) && ({1'b0, DrawX} < X_HI) &&
                       ({1'b0, DrawY} >= Y_LO) && ({1'b0, DrawY} < Y_HI);

    // Pick the committed digit under the pixel; index 0 is the leftmost (MSD)
    always_comb begin
        code_sel = 4'hF;
        for (int i = 0; i < NUM_DIGIT; i++) begin
            if (digit_idx == 10'(i)) code_sel = bank[4*(NUM_DIGIT-1-i) +: 4];
        end
    end

    // Registered render outputs, one cycle behind DrawX/DrawY
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            IsDigit   <= 1'b0;
            DigitCode <= 4'hF;
            GlyphX    <= '0;
            GlyphY    <= '0;
        end else if (in_box) begin
            IsDigit   <= (code_sel != 4'hF);
            DigitCode <= code_sel;
            GlyphX    <= GX_W'(rel_x);
            GlyphY    <= GY_W'(DrawY - 10'(COOR_Y));
        end else begin
            IsDigit   <= 1'b0;
            DigitCode <= 4'hF;
            GlyphX    <= '0;
            GlyphY    <= '0;
        end
    end

endmodule
